fliop_2: RTL and testbench

ID/EX pipeline register of the RV32 core: captures the decoded instruction, its control selects and the register/CSR read data at the end of decode and presents them to execute one cycle later. It supports a hold (stall) that freezes its contents and an optional flush that inserts a bubble. It is pure storage: no decoding, no arithmetic.

---
 rtl/fliop_2_pkg.sv | 28 ++
 rtl/fliop_2_dff.sv | 49 ++++
 rtl/fliop_2.sv | 101 ++++++++++
 tb/tb_fliop_2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fliop_2_pkg.sv
// fliop_2_pkg
//   Shared core widths, control levels and the bubble constants used by the
//   ID/EX pipeline register (fliop_2) and its per-field storage (pipe_dff).
//   Optional feature macro used by fliop_2: FLIOP2_FLUSH_EN.
package fliop_2_pkg;

   localparam int unsigned INST_WIDTH      = 32;
   localparam int unsigned INST_ADDR_WIDTH = 32;
   localparam int unsigned REG_ADDR_WIDTH  = 5;
   localparam int unsigned CSR_ADDR_WIDTH  = 12;
   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned OP1_SEL         = 2;
   localparam int unsigned OP2_SEL         = 2;
   localparam int unsigned ALU_SEL         = 4;
   localparam int unsigned BR_SEL          = 3;
   localparam int unsigned WB_SEL          = 3;
   localparam int unsigned MEM_RW          = 2;
   localparam int unsigned BYTE_SEL        = 4;

   localparam logic RST   = 1'b1;
   localparam logic UNRST = 1'b0;
   localparam logic HOLD  = 1'b1;

   // addi x0,x0,0: the instruction word of a pipeline bubble
   localparam logic [INST_WIDTH-1:0]      NOP           = 32'h0000_0013;
   localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = 32'h0000_0000;

endpackage

// File: rtl/fliop_2_dff.sv
// pipe_dff
//   Parameterized pipeline field register.
//   Priority on each rising edge: rst > clr > en (load) > keep.
//   Both rst and clr load RST_VAL, so a clear is a bubble for this field.
// Ports:
//   clk  in  1      core clock
//   rst  in  1      synchronous active-high reset
//   en   in  1      1 = load d
//   clr  in  1      1 = load RST_VAL (overrides en)
//   d    in  WIDTH  next value
//   q    out WIDTH  registered value
module pipe_dff
   import fliop_2_pkg::*;
#(
   parameter int unsigned       WIDTH   = 32,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = RST_VAL;
      end else if (en) begin
         q_d = d;
      end
   end

   // rst is tested first so an unknown en/clr during reset cannot leak in
   always_ff @(posedge clk) begin
      if (rst == RST) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/fliop_2.sv
// fliop_2
//   ID/EX pipeline register of the RV32 core. Captures decoded instruction,
//   control selects and register/CSR read data, presenting them to execute
//   one cycle later. All outputs come straight from flops.
//   Priority per edge: rst > flush (if built) > hold > load.
//   Reset and flush load the bubble: inst_o = NOP, everything else 0.
// Optional feature macro: FLIOP2_FLUSH_EN adds the flush port.
// Ports:
//   clk, rst, hold, [flush]      control
//   inst/inst_addr/rd_waddr/csr_waddr/imm            decoded instruction
//   op1_sel/op2_sel/alu_sel/br_sel/wb_sel/mem_rw/byte_sel/un_sign  selects
//   rs1_rdata/rs2_rdata/csr_rdata                    operand data
//   each with a matching registered *_o output
module fliop_2
   import fliop_2_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold,
`ifdef FLIOP2_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic [INST_WIDTH-1:0]      inst,
   input  logic [INST_ADDR_WIDTH-1:0] inst_addr,
   input  logic [REG_ADDR_WIDTH-1:0]  rd_waddr,
   input  logic [CSR_ADDR_WIDTH-1:0]  csr_waddr,
   input  logic [DATA_WIDTH-1:0]      imm,
   input  logic [OP1_SEL-1:0]         op1_sel,
   input  logic [OP2_SEL-1:0]         op2_sel,
   input  logic [ALU_SEL-1:0]         alu_sel,
   input  logic [BR_SEL-1:0]          br_sel,
   input  logic [WB_SEL-1:0]          wb_sel,
   input  logic [MEM_RW-1:0]          mem_rw,
   input  logic [BYTE_SEL-1:0]        byte_sel,
   input  logic                       un_sign,
   input  logic [DATA_WIDTH-1:0]      rs1_rdata,
   input  logic [DATA_WIDTH-1:0]      rs2_rdata,
   input  logic [DATA_WIDTH-1:0]      csr_rdata,
   output logic [INST_WIDTH-1:0]      inst_o,
   output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
   output logic [REG_ADDR_WIDTH-1:0]  rd_waddr_o,
   output logic [CSR_ADDR_WIDTH-1:0]  csr_waddr_o,
   output logic [DATA_WIDTH-1:0]      imm_o,
   output logic [OP1_SEL-1:0]         op1_sel_o,
   output logic [OP2_SEL-1:0]         op2_sel_o,
   output logic [ALU_SEL-1:0]         alu_sel_o,
   output logic [BR_SEL-1:0]          br_sel_o,
   output logic [WB_SEL-1:0]          wb_sel_o,
   output logic [MEM_RW-1:0]          mem_rw_o,
   output logic [BYTE_SEL-1:0]        byte_sel_o,
   output logic                       un_sign_o,
   output logic [DATA_WIDTH-1:0]      rs1_rdata_o,
   output logic [DATA_WIDTH-1:0]      rs2_rdata_o,
   output logic [DATA_WIDTH-1:0]      csr_rdata_o
);

   logic load_en;
   logic clr;

   // one shared enable/clear keeps every field moving in lockstep
   assign load_en = (hold != HOLD);
`ifdef FLIOP2_FLUSH_EN
   assign clr = flush;
`else
   assign clr = 1'b0;
`endif

   pipe_dff #(.WIDTH(INST_WIDTH), .RST_VAL(NOP)) u_inst (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(inst), .q(inst_o));
   pipe_dff #(.WIDTH(INST_ADDR_WIDTH), .RST_VAL(INI_INST_ADDR)) u_inst_addr (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(inst_addr), .q(inst_addr_o));
   pipe_dff #(.WIDTH(REG_ADDR_WIDTH)) u_rd_waddr (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(rd_waddr), .q(rd_waddr_o));
   pipe_dff #(.WIDTH(CSR_ADDR_WIDTH)) u_csr_waddr (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(csr_waddr), .q(csr_waddr_o));
   pipe_dff #(.WIDTH(DATA_WIDTH)) u_imm (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(imm), .q(imm_o));
   pipe_dff #(.WIDTH(OP1_SEL)) u_op1_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(op1_sel), .q(op1_sel_o));
   pipe_dff #(.WIDTH(OP2_SEL)) u_op2_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(op2_sel), .q(op2_sel_o));
   pipe_dff #(.WIDTH(ALU_SEL)) u_alu_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(alu_sel), .q(alu_sel_o));
   pipe_dff #(.WIDTH(BR_SEL)) u_br_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(br_sel), .q(br_sel_o));
   pipe_dff #(.WIDTH(WB_SEL)) u_wb_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(wb_sel), .q(wb_sel_o));
   pipe_dff #(.WIDTH(MEM_RW)) u_mem_rw (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(mem_rw), .q(mem_rw_o));
   pipe_dff #(.WIDTH(BYTE_SEL)) u_byte_sel (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(byte_sel), .q(byte_sel_o));
   pipe_dff #(.WIDTH(1)) u_un_sign (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(un_sign), .q(un_sign_o));
   pipe_dff #(.WIDTH(DATA_WIDTH)) u_rs1_rdata (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(rs1_rdata), .q(rs1_rdata_o));
   pipe_dff #(.WIDTH(DATA_WIDTH)) u_rs2_rdata (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(rs2_rdata), .q(rs2_rdata_o));
   pipe_dff #(.WIDTH(DATA_WIDTH)) u_csr_rdata (
      .clk(clk), .rst(rst), .en(load_en), .clr(clr), .d(csr_rdata), .q(csr_rdata_o));

endmodule

// File: tb/tb_fliop_2.sv
module tb_fliop_2;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] inst_addr;
      logic [4:0]  rd_waddr;
      logic [11:0] csr_waddr;
      logic [31:0] imm;
      logic [1:0]  op1_sel;
      logic [1:0]  op2_sel;
      logic [3:0]  alu_sel;
      logic [2:0]  br_sel;
      logic [2:0]  wb_sel;
      logic [1:0]  mem_rw;
      logic [3:0]  byte_sel;
      logic        un_sign;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [31:0] csr_rdata;
   } fields_t;

   typedef struct {
      string   name;
      logic    rst;
      logic    hold;
      logic    flush;
      fields_t din;
      fields_t exp;
   } vec_t;

   logic    clk = 1'b0;
   logic    rst;
   logic    hold;
   logic    flush;
   fields_t din;
   fields_t dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fliop_2 dut (
      .clk(clk), .rst(rst), .hold(hold),
`ifdef FLIOP2_FLUSH_EN
      .flush(flush),
`endif
      .inst(din.inst), .inst_addr(din.inst_addr), .rd_waddr(din.rd_waddr),
      .csr_waddr(din.csr_waddr), .imm(din.imm), .op1_sel(din.op1_sel),
      .op2_sel(din.op2_sel), .alu_sel(din.alu_sel), .br_sel(din.br_sel),
      .wb_sel(din.wb_sel), .mem_rw(din.mem_rw), .byte_sel(din.byte_sel),
      .un_sign(din.un_sign), .rs1_rdata(din.rs1_rdata), .rs2_rdata(din.rs2_rdata),
      .csr_rdata(din.csr_rdata),
      .inst_o(dout.inst), .inst_addr_o(dout.inst_addr), .rd_waddr_o(dout.rd_waddr),
      .csr_waddr_o(dout.csr_waddr), .imm_o(dout.imm), .op1_sel_o(dout.op1_sel),
      .op2_sel_o(dout.op2_sel), .alu_sel_o(dout.alu_sel), .br_sel_o(dout.br_sel),
      .wb_sel_o(dout.wb_sel), .mem_rw_o(dout.mem_rw), .byte_sel_o(dout.byte_sel),
      .un_sign_o(dout.un_sign), .rs1_rdata_o(dout.rs1_rdata), .rs2_rdata_o(dout.rs2_rdata),
      .csr_rdata_o(dout.csr_rdata)
   );

   function automatic fields_t bubble();
      fields_t f = '0;
      f.inst = 32'h0000_0013;
      return f;
   endfunction

   function automatic fields_t addi_f();
      fields_t f = '0;
      f.inst      = 32'h0010_8F93;
      f.inst_addr = 32'h0000_0100;
      f.rd_waddr  = 5'd31;
      f.imm       = 32'd1;
      f.op1_sel   = 2'd1;
      f.op2_sel   = 2'd3;
      f.alu_sel   = 4'd1;
      f.wb_sel    = 3'd1;
      f.un_sign   = 1'b1;
      f.rs1_rdata = 32'd2;
      f.rs2_rdata = 32'd3;
      f.csr_rdata = 32'd4;
      return f;
   endfunction

   function automatic fields_t bge_f();
      fields_t f = '0;
      f.inst      = 32'hFE20_D063;
      f.inst_addr = 32'h0000_0104;
      f.imm       = 32'hFFFF_F7E0;
      f.br_sel    = 3'd5;
      f.alu_sel   = 4'd2;
      f.rs1_rdata = 32'd3;
      return f;
   endfunction

   function automatic fields_t rand_f();
      fields_t f;
      f.inst      = $urandom;
      f.inst_addr = $urandom;
      f.rd_waddr  = 5'($urandom);
      f.csr_waddr = 12'($urandom);
      f.imm       = $urandom;
      f.op1_sel   = 2'($urandom);
      f.op2_sel   = 2'($urandom);
      f.alu_sel   = 4'($urandom);
      f.br_sel    = 3'($urandom);
      f.wb_sel    = 3'($urandom);
      f.mem_rw    = 2'($urandom);
      f.byte_sel  = 4'($urandom);
      f.un_sign   = 1'($urandom);
      f.rs1_rdata = $urandom;
      f.rs2_rdata = $urandom;
      f.csr_rdata = $urandom;
      return f;
   endfunction

   task automatic check(input string name, input fields_t act, input fields_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   vec_t    vecs[$];
   fields_t model;
   logic    has_flush;

   task automatic add(input string n, input logic r, input logic h, input logic fl,
                      input fields_t d, input fields_t e);
      vec_t v;
      v.name = n; v.rst = r; v.hold = h; v.flush = fl; v.din = d; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
`ifdef FLIOP2_FLUSH_EN
      has_flush = 1'b1;
`else
      has_flush = 1'b0;
`endif
      rst = 1'b1; hold = 1'b0; flush = 1'b0; din = '0;

      add("reset_hold_x",     1'b1, 1'bx, 1'b0, addi_f(), bubble());
      add("reset_ignores_in", 1'b1, 1'b0, 1'b0, addi_f(), bubble());
      add("load_addi",        1'b0, 1'b0, 1'b0, addi_f(), addi_f());
      add("hold_1",           1'b0, 1'b1, 1'b0, bge_f(),  addi_f());
      add("hold_2",           1'b0, 1'b1, 1'b0, bge_f(),  addi_f());
      add("release_addi",     1'b0, 1'b0, 1'b0, addi_f(), addi_f());
      add("release_bge",      1'b0, 1'b0, 1'b0, bge_f(),  bge_f());
      add("reset_mid_hold",   1'b1, 1'b1, 1'b0, bge_f(),  bubble());
      add("relatch_bge",      1'b0, 1'b0, 1'b0, bge_f(),  bge_f());
      add("hold_before_fl",   1'b0, 1'b1, 1'b0, addi_f(), bge_f());
      if (has_flush)
         add("flush_over_hold", 1'b0, 1'b1, 1'b1, bge_f(), bubble());
      else
         add("no_flush_hold",   1'b0, 1'b1, 1'b1, addi_f(), bge_f());
      add("load_after",       1'b0, 1'b0, 1'b0, addi_f(), addi_f());

      @(negedge clk);
      foreach (vecs[i]) begin
         rst = vecs[i].rst; hold = vecs[i].hold; flush = vecs[i].flush; din = vecs[i].din;
         @(posedge clk); #1;
         check(vecs[i].name, dout, vecs[i].exp);
         @(negedge clk);
      end

      // random traffic against the priority rules; inputs are scrambled
      // mid-cycle to confirm the outputs only move on an edge
      model = addi_f();
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 19) == 0);
         hold  = ($urandom_range(0, 2) == 0);
         flush = ($urandom_range(0, 7) == 0);
         din   = rand_f();
         @(posedge clk);
         if (rst)                    model = bubble();
         else if (flush && has_flush) model = bubble();
         else if (!hold)             model = din;
         #1;
         check("rand_edge", dout, model);
         din = rand_f(); hold = ~hold; rst = ~rst;
         #3;
         check("rand_stable", dout, model);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
